// File: rtl/game_controller_if.sv
// Game controller side-bus: random-digit handshake plus countdown-timer control.
// The master modport is the controller; the slave modport is the digit
// sequencer / timer side.
interface game_controller_if;
    logic       rand_req;
    logic       rand_valid;
    logic [3:0] rand_digit;
    logic       timeout;
    logic       timer_reconfig;
    logic       timer_enable;

    modport master (
        output rand_req,
        input  rand_valid,
        input  rand_digit,
        input  timeout,
        output timer_reconfig,
        output timer_enable
    );

    modport slave (
        input  rand_req,
        output rand_valid,
        output rand_digit,
        output timeout,
        input  timer_reconfig,
        input  timer_enable
    );
endinterface

// File: rtl/game_controller.sv
// game_controller: round sequencer for the memory-digit game.
// Arms the timer, fetches a random digit, shows it, scores the player's
// entry and raises the level every HITS_PER_LEVEL hits. Timeout ends the game
// and pulses gc_logout.
// Optional build macro GC_MISS_PENALTY_EN: a miss decrements score
// (saturating at 0) and clears the hit counter. Undefined: a miss is a no-op.
module game_controller #(
    parameter int unsigned HITS_PER_LEVEL = 4,
    parameter int unsigned MAX_LEVEL      = 3,
    parameter logic [3:0]  BLANK_CODE     = 4'hF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              logged_in,
    input  logic              start_btn,
    input  logic [3:0]        user_digit,
    game_controller_if.master gc_bus,
    output logic [1:0]        game_level,
    output logic [3:0]        rand_display,
    output logic [3:0]        player_display,
    output logic [7:0]        score,
    output logic              gc_logout
);

    localparam logic [3:0] HIT_LAST  = 4'(HITS_PER_LEVEL - 1);
    localparam logic [1:0] LEVEL_TOP = 2'(MAX_LEVEL);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_FETCH = 3'd2,
        ST_SHOW  = 3'd3,
        ST_CHECK = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    state_t     state_r, state_s;
    logic [3:0] captured_r, captured_s;
    logic [3:0] player_r, player_s;
    logic [7:0] score_r, score_s;
    logic [3:0] hit_r, hit_s;
    logic [1:0] level_r, level_s;
    logic       rand_req_r, rand_req_s;
    logic       reconfig_r, reconfig_s;
    logic       enable_r, enable_s;
    logic       logout_r, logout_s;
    logic [3:0] rand_disp_r, rand_disp_s;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? 8'hFF : v + 8'd1;
    endfunction

    function automatic logic [7:0] sat_dec8(input logic [7:0] v);
        return (v == 8'h00) ? 8'h00 : v - 8'd1;
    endfunction

    // Next-state and datapath updates; logout beats timeout beats button/strobe.
    always_comb begin
        state_s    = state_r;
        captured_s = captured_r;
        player_s   = player_r;
        score_s    = score_r;
        hit_s      = hit_r;
        level_s    = level_r;
        if (!logged_in) begin
            state_s  = ST_IDLE;
            player_s = BLANK_CODE;
            hit_s    = 4'd0;
            level_s  = 2'd0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start_btn) begin
                        state_s = ST_ARM;
                        score_s = 8'd0;
                        hit_s   = 4'd0;
                        level_s = 2'd0;
                    end else begin
                        state_s = state_r;
                    end
                end
                ST_ARM: begin
                    state_s = ST_FETCH;
                end
                ST_FETCH: begin
                    if (gc_bus.timeout) begin
                        state_s = ST_DONE;
                    end else if (gc_bus.rand_valid) begin
                        captured_s = gc_bus.rand_digit;
                        state_s    = ST_SHOW;
                    end else begin
                        state_s = ST_FETCH;
                    end
                end
                ST_SHOW: begin
                    if (gc_bus.timeout) begin
                        state_s = ST_DONE;
                    end else if (start_btn) begin
                        player_s = user_digit;
                        state_s  = ST_CHECK;
                    end else begin
                        state_s = ST_SHOW;
                    end
                end
                ST_CHECK: begin
                    if (gc_bus.timeout) begin
                        state_s = ST_DONE;
                    end else if (player_r == captured_r) begin
                        score_s = sat_inc8(score_r);
                        if (hit_r == HIT_LAST) begin
                            hit_s   = 4'd0;
                            level_s = (level_r == LEVEL_TOP) ? LEVEL_TOP : level_r + 2'd1;
                            state_s = ST_ARM;
                        end else begin
                            hit_s   = hit_r + 4'd1;
                            state_s = ST_FETCH;
                        end
                    end else begin
`ifdef GC_MISS_PENALTY_EN
                        score_s = sat_dec8(score_r);
                        hit_s   = 4'd0;
`else
                        score_s = score_r;
`endif
                        state_s = ST_FETCH;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // Output values for the coming cycle, derived from the state being entered.
    always_comb begin
        rand_req_s  = 1'b0;
        reconfig_s  = 1'b0;
        enable_s    = 1'b0;
        logout_s    = 1'b0;
        rand_disp_s = BLANK_CODE;
        case (state_s)
            ST_ARM: begin
                reconfig_s = 1'b1;
            end
            ST_FETCH: begin
                rand_req_s = 1'b1;
                enable_s   = 1'b1;
            end
            ST_SHOW, ST_CHECK: begin
                enable_s    = 1'b1;
                rand_disp_s = captured_s;
            end
            ST_DONE: begin
                logout_s = (state_r != ST_DONE) ? 1'b1 : 1'b0;
            end
            default: begin
                rand_req_s = 1'b0;
            end
        endcase
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            captured_r  <= 4'd0;
            player_r    <= BLANK_CODE;
            score_r     <= 8'd0;
            hit_r       <= 4'd0;
            level_r     <= 2'd0;
            rand_req_r  <= 1'b0;
            reconfig_r  <= 1'b0;
            enable_r    <= 1'b0;
            logout_r    <= 1'b0;
            rand_disp_r <= BLANK_CODE;
        end else begin
            state_r     <= state_s;
            captured_r  <= captured_s;
            player_r    <= player_s;
            score_r     <= score_s;
            hit_r       <= hit_s;
            level_r     <= level_s;
            rand_req_r  <= rand_req_s;
            reconfig_r  <= reconfig_s;
            enable_r    <= enable_s;
            logout_r    <= logout_s;
            rand_disp_r <= rand_disp_s;
        end
    end

    assign gc_bus.rand_req       = rand_req_r;
    assign gc_bus.timer_reconfig = reconfig_r;
    assign gc_bus.timer_enable   = enable_r;
    assign game_level            = level_r;
    assign rand_display          = rand_disp_r;
    assign player_display        = player_r;
    assign score                 = score_r;
    assign gc_logout             = logout_r;

endmodule

// File: tb/tb_game_controller.sv
// Directed bench for game_controller: reset, basic round, level-up and
// saturation, miss handling, timeout collision, logout and mid-game reset.
module tb_game_controller;
    logic       clk;
    logic       rst;
    logic       logged_in;
    logic       start_btn;
    logic [3:0] user_digit;
    logic [1:0] game_level;
    logic [3:0] rand_display;
    logic [3:0] player_display;
    logic [7:0] score;
    logic       gc_logout;
    int         checks;
    int         failures;

    game_controller_if bus ();

    game_controller dut (
        .clk           (clk),
        .rst           (rst),
        .logged_in     (logged_in),
        .start_btn     (start_btn),
        .user_digit    (user_digit),
        .gc_bus        (bus.master),
        .game_level    (game_level),
        .rand_display  (rand_display),
        .player_display(player_display),
        .score         (score),
        .gc_logout     (gc_logout)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // From FETCH: deliver digit d, enter u, pass CHECK; extra tick leaves ARM.
    task automatic do_round(input logic [3:0] d, input logic [3:0] u, input bit level_up);
        bus.rand_valid = 1'b1;
        bus.rand_digit = d;
        tick();
        bus.rand_valid = 1'b0;
        user_digit     = u;
        start_btn      = 1'b1;
        tick();
        start_btn = 1'b0;
        tick();
        if (level_up) tick();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        logged_in = 1'b0;
        start_btn = 1'b0;
        user_digit = 4'd0;
        bus.rand_valid = 1'b0;
        bus.rand_digit = 4'd0;
        bus.timeout = 1'b0;
        tick();
        check("rst_rand_req", 8'(bus.rand_req), 8'd0);
        check("rst_reconfig", 8'(bus.timer_reconfig), 8'd0);
        check("rst_enable", 8'(bus.timer_enable), 8'd0);
        check("rst_logout", 8'(gc_logout), 8'd0);
        check("rst_level", 8'(game_level), 8'd0);
        check("rst_score", score, 8'd0);
        check("rst_rdisp", 8'(rand_display), 8'h0F);
        check("rst_pdisp", 8'(player_display), 8'h0F);

        // Basic round.
        rst = 1'b0;
        logged_in = 1'b1;
        tick();
        start_btn = 1'b1;
        tick();
        start_btn = 1'b0;
        check("arm_reconfig", 8'(bus.timer_reconfig), 8'd1);
        check("arm_enable", 8'(bus.timer_enable), 8'd0);
        check("arm_rand_req", 8'(bus.rand_req), 8'd0);
        tick();
        check("fetch_reconfig", 8'(bus.timer_reconfig), 8'd0);
        check("fetch_rand_req", 8'(bus.rand_req), 8'd1);
        check("fetch_enable", 8'(bus.timer_enable), 8'd1);
        bus.rand_valid = 1'b1;
        bus.rand_digit = 4'd7;
        tick();
        bus.rand_valid = 1'b0;
        check("show_rdisp", 8'(rand_display), 8'd7);
        check("show_rand_req", 8'(bus.rand_req), 8'd0);
        user_digit = 4'd7;
        start_btn = 1'b1;
        tick();
        start_btn = 1'b0;
        check("check_pdisp", 8'(player_display), 8'd7);
        check("check_score_lat", score, 8'd0);
        tick();
        check("hit1_score", score, 8'd1);
        check("hit1_rand_req", 8'(bus.rand_req), 8'd1);
        check("hit1_rdisp", 8'(rand_display), 8'h0F);

        // Three more hits reach level 1 with a reconfig pulse.
        do_round(4'd3, 4'd3, 1'b0);
        do_round(4'd0, 4'd0, 1'b0);
        do_round(4'd9, 4'd9, 1'b0);
        check("lvl1_reconfig", 8'(bus.timer_reconfig), 8'd1);
        check("lvl1_level", 8'(game_level), 8'd1);
        check("lvl1_score", score, 8'd4);
        tick();
        for (int i = 0; i < 8; i++) do_round(4'(i % 10), 4'(i % 10), (i % 4) == 3);
        check("lvl3_level", 8'(game_level), 8'd3);
        check("lvl3_score", score, 8'd12);
        for (int i = 0; i < 3; i++) do_round(4'd2, 4'd2, 1'b0);
        do_round(4'd8, 4'd8, 1'b0);
        check("sat_reconfig", 8'(bus.timer_reconfig), 8'd1);
        check("sat_level", 8'(game_level), 8'd3);
        check("sat_score", score, 8'd16);
        tick();

        // Two hits, a miss, two hits: the miss behaviour decides level-up.
        do_round(4'd1, 4'd1, 1'b0);
        do_round(4'd4, 4'd4, 1'b0);
        do_round(4'd5, 4'd2, 1'b0);
`ifdef GC_MISS_PENALTY_EN
        check("miss_score", score, 8'd17);
`else
        check("miss_score", score, 8'd18);
`endif
        check("miss_pdisp", 8'(player_display), 8'd2);
        do_round(4'd6, 4'd6, 1'b0);
        do_round(4'd6, 4'd6, 1'b0);
`ifdef GC_MISS_PENALTY_EN
        check("post_miss_reconfig", 8'(bus.timer_reconfig), 8'd0);
        check("post_miss_score", score, 8'd19);
`else
        check("post_miss_reconfig", 8'(bus.timer_reconfig), 8'd1);
        check("post_miss_score", score, 8'd20);
        tick();
`endif

        // Timeout collides with start_btn in SHOW.
        bus.rand_valid = 1'b1;
        bus.rand_digit = 4'd4;
        tick();
        bus.rand_valid = 1'b0;
        user_digit = 4'd4;
        start_btn = 1'b1;
        bus.timeout = 1'b1;
        tick();
        start_btn = 1'b0;
        check("to_logout", 8'(gc_logout), 8'd1);
        check("to_enable", 8'(bus.timer_enable), 8'd0);
        check("to_pdisp", 8'(player_display), 8'd6);
        check("to_rdisp", 8'(rand_display), 8'h0F);
        tick();
        bus.timeout = 1'b0;
        check("to_logout_pulse", 8'(gc_logout), 8'd0);
`ifdef GC_MISS_PENALTY_EN
        check("to_score_hold", score, 8'd19);
`else
        check("to_score_hold", score, 8'd20);
`endif

        // Restart from DONE clears score and level.
        start_btn = 1'b1;
        tick();
        start_btn = 1'b0;
        check("restart_reconfig", 8'(bus.timer_reconfig), 8'd1);
        check("restart_score", score, 8'd0);
        check("restart_level", 8'(game_level), 8'd0);
        tick();

        // Logout during FETCH.
        do_round(4'd6, 4'd6, 1'b0);
        logged_in = 1'b0;
        tick();
        check("lo_rand_req", 8'(bus.rand_req), 8'd0);
        check("lo_rdisp", 8'(rand_display), 8'h0F);
        check("lo_pdisp", 8'(player_display), 8'h0F);
        check("lo_score_hold", score, 8'd1);
        logged_in = 1'b1;
        start_btn = 1'b1;
        tick();
        start_btn = 1'b0;
        check("lo_restart_score", score, 8'd0);
        tick();

        // Reset in SHOW with score 9.
        for (int i = 0; i < 9; i++) do_round(4'd5, 4'd5, (i % 4) == 3);
        bus.rand_valid = 1'b1;
        bus.rand_digit = 4'd3;
        tick();
        bus.rand_valid = 1'b0;
        check("pre_rst_score", score, 8'd9);
        check("pre_rst_level", 8'(game_level), 8'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_score", score, 8'd0);
        check("mid_rst_level", 8'(game_level), 8'd0);
        check("mid_rst_enable", 8'(bus.timer_enable), 8'd0);
        check("mid_rst_rdisp", 8'(rand_display), 8'h0F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
